// File: rtl/mem_fu_pkg.sv
// Shared types for the memory functional unit: size codes, FSM states, store-queue entry and lane helpers.
// Datapath lanes are fixed at four bytes (32-bit memory words).
package mem_fu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    BCAST  = 2'd2
  } mem_state_t;

  localparam int LANES      = 4;
  localparam int SQ_WADDR_W = 30;
  localparam int SQ_TAG_W   = 8;

  typedef struct packed {
    logic [SQ_WADDR_W-1:0] waddr;
    logic [LANES-1:0]      be;
    logic [31:0]           data;
    logic [SQ_TAG_W-1:0]   tag;
  } sq_entry_t;

  function automatic logic [LANES-1:0] byte_en(input mem_size_t sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: byte_en = 4'b0001 << off;
      SZ_HALF: byte_en = off[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] align_data(input mem_size_t sz, input logic [31:0] d);
    case (sz)
      SZ_BYTE: align_data = {4{d[7:0]}};
      SZ_HALF: align_data = {2{d[15:0]}};
      default: align_data = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input mem_size_t sz,
                                               input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = word[16*off[1] +: 16];
    case (sz)
      SZ_BYTE: load_extract = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: load_extract = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: load_extract = word;
    endcase
  endfunction

endpackage

// File: rtl/mem_fu_if.sv
// Issue / CDB / commit bundle between the reservation stations, ROB and the memory unit.
// slave = memory unit view, master = surrounding pipeline view.
interface mem_fu_if #(
  parameter int DATA_W    = 32,
  parameter int PHY_REG_W = 7,
  parameter int TAG_W     = 6
);
  logic                 issue_valid;
  logic                 issue_ready;
  logic                 issue_is_store;
  logic [1:0]           issue_size;
  logic                 issue_unsigned;
  logic [DATA_W-1:0]    issue_base;
  logic [DATA_W-1:0]    issue_imm;
  logic [DATA_W-1:0]    issue_st_data;
  logic [PHY_REG_W-1:0] issue_dst_phy;
  logic [TAG_W-1:0]     issue_tag;
  logic                 cdb_req;
  logic                 cdb_grant;
  logic [DATA_W-1:0]    cdb_value;
  logic [PHY_REG_W-1:0] cdb_phy;
  logic [TAG_W-1:0]     cdb_tag;
  logic                 cdb_is_store;
  logic                 cdb_exc;
  logic                 commit_store;
  logic                 flush;
  logic                 sq_full;

  modport slave (
    input  issue_valid, issue_is_store, issue_size, issue_unsigned, issue_base, issue_imm,
           issue_st_data, issue_dst_phy, issue_tag, cdb_grant, commit_store, flush,
    output issue_ready, cdb_req, cdb_value, cdb_phy, cdb_tag, cdb_is_store, cdb_exc, sq_full
  );

  modport master (
    output issue_valid, issue_is_store, issue_size, issue_unsigned, issue_base, issue_imm,
           issue_st_data, issue_dst_phy, issue_tag, cdb_grant, commit_store, flush,
    input  issue_ready, cdb_req, cdb_value, cdb_phy, cdb_tag, cdb_is_store, cdb_exc, sq_full
  );
endinterface

// File: rtl/mem_store_queue.sv
// Circular store queue holding speculative stores until ROB commit; flush discards every entry.
// Per-entry valid bits give a word-address match vector for load hazard detection.
module mem_store_queue
  import mem_fu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  sq_entry_t             i_push_entry,
  input  logic                  i_pop,
  input  logic                  i_flush,
  input  logic [SQ_WADDR_W-1:0] i_match_waddr,
  output sq_entry_t             o_head,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [DEPTH-1:0]      o_match_vec
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sq_entry_t        r_entries [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = r_entries[r_head];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      o_match_vec[i] = r_valid[i] & (r_entries[i].waddr == i_match_waddr);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_entries[r_tail] <= i_push_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // Clear before set so full+pop+push onto the same slot keeps it valid.
      if (w_do_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_do_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_exec_unit.sv
// Memory functional unit: one load/store at a time, load latency MEM_LAT, results broadcast on the CDB.
// Optional MEM_MISALIGN_CHECK_EN raises cdb_exc on misaligned half/word instead of force-aligning.
module mem_exec_unit
  import mem_fu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PHY_REG_W = 7,
  parameter int TAG_W     = 6,
  parameter int MEM_WORDS = 1024,
  parameter int MEM_LAT   = 2,
  parameter int SQ_DEPTH  = 4
) (
  input  logic    clk,
  input  logic    reset,
  mem_fu_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  mem_state_t           r_state;
  mem_state_t           w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_is_store;
  logic                 r_uns;
  mem_size_t            r_size;
  logic [DATA_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_st_data;
  logic [PHY_REG_W-1:0] r_phy;
  logic [TAG_W-1:0]     r_tag;
  logic [DATA_W-1:0]    r_cdb_value;
  logic                 r_cdb_is_store;
  logic                 r_cdb_exc;
  logic [DATA_W-1:0]    r_mem [MEM_WORDS];

  mem_size_t             w_size;
  logic [DATA_W-1:0]     w_addr_raw;
  logic [DATA_W-1:0]     w_addr;
  logic                  w_bad_align;
  logic                  w_accept;
  logic                  w_sq_push;
  logic                  w_sq_pop;
  logic                  w_sq_empty;
  logic                  w_sq_full;
  logic                  w_load_done;
  logic                  w_hazard;
  logic [SQ_DEPTH-1:0]   w_match_vec;
  logic [IDX_W-1:0]      w_idx;
  logic [SQ_WADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0]     w_ld_word;
  sq_entry_t             w_push_entry;
  sq_entry_t             w_sq_head;
  logic                  w_unused_ok;

  assign w_size     = mem_size_t'(bus.issue_size);
  assign w_addr_raw = bus.issue_base + bus.issue_imm;

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    case (w_size)
      SZ_BYTE: w_bad_align = 1'b0;
      SZ_HALF: w_bad_align = w_addr_raw[0];
      default: w_bad_align = |w_addr_raw[1:0];
    endcase
  end
  assign w_addr = w_addr_raw;
`else
  assign w_bad_align = 1'b0;
  always_comb begin
    w_addr = w_addr_raw;
    case (w_size)
      SZ_BYTE: w_addr = w_addr_raw;
      SZ_HALF: w_addr[0] = 1'b0;
      default: w_addr[1:0] = 2'b00;
    endcase
  end
`endif

  assign bus.issue_ready = (r_state == IDLE) & ~bus.flush & ~(bus.issue_is_store & w_sq_full);
  assign w_accept        = bus.issue_valid & bus.issue_ready;

  assign w_idx    = r_addr[2 +: IDX_W];
  assign w_hazard = |w_match_vec;
  assign w_sq_pop = bus.commit_store & ~w_sq_empty;
  assign w_ld_word = r_mem[w_idx];

  always_comb begin
    w_waddr              = '0;
    w_waddr[IDX_W-1:0]   = w_idx;
    w_push_entry         = '0;
    w_push_entry.waddr   = w_waddr;
    w_push_entry.be      = byte_en(r_size, r_addr[1:0]);
    w_push_entry.data    = align_data(r_size, r_st_data);
    w_push_entry.tag[TAG_W-1:0] = r_tag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sq_push   = 1'b0;
    w_load_done = 1'b0;
    case (r_state)
      IDLE:   if (w_accept) w_state_nxt = w_bad_align ? BCAST : ACCESS;
      ACCESS: if (r_cnt == '0) begin
                if (r_is_store) begin
                  w_sq_push   = 1'b1;
                  w_state_nxt = BCAST;
                end else if (!w_hazard) begin
                  w_load_done = 1'b1;
                  w_state_nxt = BCAST;
                end
              end
      BCAST:  if (bus.cdb_grant) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (bus.flush) begin
      w_state_nxt = IDLE;
      w_sq_push   = 1'b0;
      w_load_done = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt          <= '0;
      r_is_store     <= 1'b0;
      r_uns          <= 1'b0;
      r_size         <= SZ_BYTE;
      r_addr         <= '0;
      r_st_data      <= '0;
      r_phy          <= '0;
      r_tag          <= '0;
      r_cdb_value    <= '0;
      r_cdb_is_store <= 1'b0;
      r_cdb_exc      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_is_store     <= bus.issue_is_store;
        r_uns          <= bus.issue_unsigned;
        r_size         <= w_size;
        r_addr         <= w_addr;
        r_st_data      <= bus.issue_st_data;
        r_phy          <= bus.issue_dst_phy;
        r_tag          <= bus.issue_tag;
        r_cnt          <= bus.issue_is_store ? '0 : CNT_W'(MEM_LAT - 1);
        r_cdb_is_store <= bus.issue_is_store;
        r_cdb_exc      <= w_bad_align;
        r_cdb_value    <= w_bad_align ? w_addr_raw : '0;
      end else if (r_state == ACCESS && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_load_done) r_cdb_value <= load_extract(w_ld_word, r_size, r_addr[1:0], r_uns);
    end
  end

  // Memory is architectural state only updated at commit; reset leaves it untouched.
  always_ff @(posedge clk) begin
    if (w_sq_pop) begin
      for (int b = 0; b < LANES; b++) begin
        if (w_sq_head.be[b]) r_mem[w_sq_head.waddr[IDX_W-1:0]][8*b +: 8] <= w_sq_head.data[8*b +: 8];
      end
    end
  end

  mem_store_queue #(.DEPTH(SQ_DEPTH)) u_sq (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_sq_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_sq_pop),
    .i_flush      (bus.flush),
    .i_match_waddr(w_waddr),
    .o_head       (w_sq_head),
    .o_empty      (w_sq_empty),
    .o_full       (w_sq_full),
    .o_match_vec  (w_match_vec)
  );

  assign bus.cdb_req      = (r_state == BCAST);
  assign bus.cdb_value    = r_cdb_value;
  assign bus.cdb_phy      = r_phy;
  assign bus.cdb_tag      = r_tag;
  assign bus.cdb_is_store = r_cdb_is_store;
  assign bus.cdb_exc      = r_cdb_exc;
  assign bus.sq_full      = w_sq_full;

  assign w_unused_ok = ^{r_addr, w_sq_head.tag, w_sq_head.waddr};

endmodule

// File: tb/tb_mem_exec_unit.sv
// Directed self-checking bench for mem_exec_unit (default MEM_LAT=2, SQ_DEPTH=4).
// Expected values are hand-computed from the stores the bench itself commits.
module tb_mem_exec_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_fu_if #(.DATA_W(32), .PHY_REG_W(7), .TAG_W(6)) bus ();

  mem_exec_unit #(
    .DATA_W(32), .PHY_REG_W(7), .TAG_W(6), .MEM_WORDS(1024), .MEM_LAT(2), .SQ_DEPTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] got_val;
  logic        got_exc;
  logic        got_st;
  logic [6:0]  got_phy;
  logic [5:0]  got_tag;
  int          got_lat;
  bit          got_ok;

  task automatic drive_idle();
    bus.issue_valid    = 1'b0;
    bus.issue_is_store = 1'b0;
    bus.issue_size     = 2'd2;
    bus.issue_unsigned = 1'b0;
    bus.issue_base     = '0;
    bus.issue_imm      = '0;
    bus.issue_st_data  = '0;
    bus.issue_dst_phy  = '0;
    bus.issue_tag      = '0;
    bus.cdb_grant      = 1'b1;
    bus.commit_store   = 1'b0;
    bus.flush          = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic issue_op(input logic st, input logic [1:0] sz, input logic uns, input logic [31:0] base,
                          input logic [31:0] imm, input logic [31:0] sdata, input logic [6:0] phy,
                          input logic [5:0] tag, output bit ok);
    ok = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_is_store = st; bus.issue_size = sz; bus.issue_unsigned = uns;
    bus.issue_base = base; bus.issue_imm = imm; bus.issue_st_data = sdata;
    bus.issue_dst_phy = phy; bus.issue_tag = tag;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (bus.issue_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    bus.issue_valid = 1'b0;
  endtask

  task automatic wait_req(output int lat, output bit ok);
    ok  = 1'b0;
    lat = 1;
    for (int i = 0; i < 60; i++) begin
      if (bus.cdb_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input logic st, input logic [1:0] sz, input logic uns, input logic [31:0] base,
                        input logic [31:0] imm, input logic [31:0] sdata, input logic [6:0] phy,
                        input logic [5:0] tag);
    bit iok;
    issue_op(st, sz, uns, base, imm, sdata, phy, tag, iok);
    wait_req(got_lat, got_ok);
    got_ok  = got_ok & iok;
    got_val = bus.cdb_value; got_exc = bus.cdb_exc; got_st = bus.cdb_is_store;
    got_phy = bus.cdb_phy;   got_tag = bus.cdb_tag;
    @(negedge clk);
  endtask

  task automatic commit_pulse(input int n);
    bus.commit_store = 1'b1;
    repeat (n) @(negedge clk);
    bus.commit_store = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    bus.flush = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.cdb_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", bus.cdb_req); end
    n_cmp++; if (bus.cdb_exc !== 1'b0) begin n_bad++; $display("FAIL rst_exc: got %b want 0", bus.cdb_exc); end
    n_cmp++; if (bus.cdb_is_store !== 1'b0) begin n_bad++; $display("FAIL rst_is_store: got %b want 0", bus.cdb_is_store); end
    n_cmp++; if (bus.cdb_value !== 32'h0) begin n_bad++; $display("FAIL rst_value: got %h want 0", bus.cdb_value); end
    n_cmp++; if (bus.sq_full !== 1'b0) begin n_bad++; $display("FAIL rst_sq_full: got %b want 0", bus.sq_full); end
    bus.flush = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.issue_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", bus.issue_ready); end
  endtask

  task automatic test_load_word();
    run_op(1'b1, 2'd2, 1'b0, 32'h8, 32'h8, 32'hDEADBEEF, 7'd0, 6'd1);
    n_cmp++; if (!got_ok || got_st !== 1'b1) begin n_bad++; $display("FAIL st_word_cdb: ok=%0b is_store=%b want 1", got_ok, got_st); end
    commit_pulse(1);
    run_op(1'b0, 2'd2, 1'b0, 32'h20, 32'hFFFFFFF0, 32'h0, 7'd5, 6'd2);
    n_cmp++; if (!got_ok || got_lat != 3) begin n_bad++; $display("FAIL ld_word_lat: ok=%0b got %0d want 3", got_ok, got_lat); end
    n_cmp++; if (got_val !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ld_word_val: got %h want deadbeef", got_val); end
    n_cmp++; if (got_phy !== 7'd5 || got_tag !== 6'd2 || got_st !== 1'b0) begin
      n_bad++; $display("FAIL ld_word_payload: phy=%0d tag=%0d st=%b want 5 2 0", got_phy, got_tag, got_st); end
  endtask

  task automatic test_load_ext();
    run_op(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h0, 7'd1, 6'd3);
    n_cmp++; if (!got_ok || got_val !== 32'hFFFFFFDE) begin n_bad++; $display("FAIL ld_byte_s: got %h want ffffffde", got_val); end
    run_op(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h0, 7'd1, 6'd3);
    n_cmp++; if (!got_ok || got_val !== 32'h000000DE) begin n_bad++; $display("FAIL ld_byte_u: got %h want 000000de", got_val); end
    run_op(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'h0, 7'd1, 6'd3);
    n_cmp++; if (!got_ok || got_val !== 32'hFFFFDEAD) begin n_bad++; $display("FAIL ld_half_s: got %h want ffffdead", got_val); end
    run_op(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 32'h0, 7'd1, 6'd3);
    n_cmp++; if (!got_ok || got_val !== 32'h0000BEEF) begin n_bad++; $display("FAIL ld_half_u: got %h want 0000beef", got_val); end
    run_op(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'h0, 7'd1, 6'd3);
    n_cmp++; if (!got_ok || got_val !== 32'hFFFFFFEF) begin n_bad++; $display("FAIL ld_byte0_s: got %h want ffffffef", got_val); end
  endtask

  task automatic test_store_hazard();
    bit iok;
    bit early;
    run_op(1'b1, 2'd2, 1'b0, 32'h20, 32'h0, 32'h0, 7'd0, 6'd4);
    commit_pulse(1);
    run_op(1'b1, 2'd0, 1'b0, 32'h20, 32'h0, 32'hABCDEF55, 7'd0, 6'd5);
    issue_op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h0, 7'd9, 6'd6, iok);
    early = 1'b0;
    repeat (8) begin
      if (bus.cdb_req) early = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (!iok || early) begin n_bad++; $display("FAIL hazard_stall: accepted=%0b req_seen=%0b want 1 0", iok, early); end
    commit_pulse(1);
    wait_req(got_lat, got_ok);
    got_val = bus.cdb_value;
    @(negedge clk);
    n_cmp++; if (!got_ok || got_val !== 32'h00000055) begin n_bad++; $display("FAIL hazard_val: ok=%0b got %h want 00000055", got_ok, got_val); end
  endtask

  task automatic test_sq_full();
    bit iok;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, 2'd0, 1'b0, 32'h40, 32'(i), 32'(8'h11 * (i + 1)), 7'd0, 6'(10 + i));
    end
    n_cmp++; if (bus.sq_full !== 1'b1) begin n_bad++; $display("FAIL sq_full_set: got %b want 1", bus.sq_full); end
    bus.issue_is_store = 1'b1; #1;
    n_cmp++; if (bus.issue_ready !== 1'b0) begin n_bad++; $display("FAIL full_store_ready: got %b want 0", bus.issue_ready); end
    bus.issue_is_store = 1'b0; #1;
    n_cmp++; if (bus.issue_ready !== 1'b1) begin n_bad++; $display("FAIL full_load_ready: got %b want 1", bus.issue_ready); end
    @(negedge clk);
    bus.commit_store = 1'b1;
    fork
      begin @(negedge clk); bus.commit_store = 1'b0; end
    join_none
    run_op(1'b1, 2'd0, 1'b0, 32'h44, 32'h0, 32'h77, 7'd0, 6'd20);
    n_cmp++; if (!got_ok || bus.sq_full !== 1'b1) begin n_bad++; $display("FAIL commit_issue_full: ok=%0b sq_full=%b want 1", got_ok, bus.sq_full); end
    commit_pulse(1);
    // Push in the same cycle as a pop: occupancy must stay at three.
    issue_op(1'b1, 2'd0, 1'b0, 32'h45, 32'h0, 32'h66, 7'd0, 6'd21, iok);
    commit_pulse(1);
    wait_req(got_lat, got_ok);
    @(negedge clk);
    n_cmp++; if (!iok || !got_ok || bus.sq_full !== 1'b0) begin n_bad++; $display("FAIL push_pop_cnt: ok=%0b sq_full=%b want 0", got_ok, bus.sq_full); end
    run_op(1'b1, 2'd0, 1'b0, 32'h46, 32'h0, 32'h88, 7'd0, 6'd22);
    n_cmp++; if (!got_ok || bus.sq_full !== 1'b1) begin n_bad++; $display("FAIL refill_full: ok=%0b sq_full=%b want 1", got_ok, bus.sq_full); end
    commit_pulse(4);
    n_cmp++; if (bus.sq_full !== 1'b0) begin n_bad++; $display("FAIL drain_full: got %b want 0", bus.sq_full); end
    run_op(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h0, 7'd2, 6'd23);
    n_cmp++; if (!got_ok || got_val !== 32'h44332211) begin n_bad++; $display("FAIL drain_word40: got %h want 44332211", got_val); end
    run_op(1'b0, 2'd1, 1'b1, 32'h44, 32'h0, 32'h0, 7'd2, 6'd24);
    n_cmp++; if (!got_ok || got_val !== 32'h00006677) begin n_bad++; $display("FAIL drain_half44: got %h want 00006677", got_val); end
    run_op(1'b0, 2'd0, 1'b1, 32'h46, 32'h0, 32'h0, 7'd2, 6'd25);
    n_cmp++; if (!got_ok || got_val !== 32'h00000088) begin n_bad++; $display("FAIL drain_byte46: got %h want 00000088", got_val); end
  endtask

  task automatic test_flush();
    bit iok;
    bit stable;
    run_op(1'b1, 2'd2, 1'b0, 32'h50, 32'h0, 32'h12345678, 7'd0, 6'd30);
    bus.cdb_grant = 1'b0;
    issue_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, 7'd3, 6'd7, iok);
    wait_req(got_lat, got_ok);
    n_cmp++; if (!iok || !got_ok || got_lat != 3) begin n_bad++; $display("FAIL bcast_lat: ok=%0b got %0d want 3", got_ok, got_lat); end
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.cdb_req !== 1'b1 || bus.cdb_value !== 32'hDEADBEEF || bus.cdb_tag !== 6'd7 || bus.cdb_phy !== 7'd3) stable = 1'b0;
    end
    n_cmp++; if (!stable) begin n_bad++; $display("FAIL bcast_hold: payload or req changed, value=%h want deadbeef", bus.cdb_value); end
    bus.flush = 1'b1; #1;
    n_cmp++; if (bus.issue_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b want 0", bus.issue_ready); end
    @(negedge clk);
    bus.flush = 1'b0;
    n_cmp++; if (bus.cdb_req !== 1'b0) begin n_bad++; $display("FAIL flush_req: got %b want 0", bus.cdb_req); end
    bus.cdb_grant = 1'b1;
    run_op(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, 32'h0, 7'd4, 6'd31);
    n_cmp++; if (!got_ok || got_lat != 3) begin n_bad++; $display("FAIL flush_sq_empty: ok=%0b lat=%0d want 3", got_ok, got_lat); end
    run_op(1'b1, 2'd2, 1'b0, 32'h54, 32'h0, 32'hCAFEF00D, 7'd0, 6'd32);
    bus.commit_store = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    bus.commit_store = 1'b0; bus.flush = 1'b0;
    run_op(1'b0, 2'd2, 1'b0, 32'h54, 32'h0, 32'h0, 7'd4, 6'd33);
    n_cmp++; if (!got_ok || got_val !== 32'hCAFEF00D) begin n_bad++; $display("FAIL flush_commit_val: got %h want cafef00d", got_val); end
  endtask

  task automatic test_misalign();
    logic [31:0] exp_h, exp_w;
    logic        exp_e;
`ifdef MEM_MISALIGN_CHECK_EN
    exp_h = 32'h21; exp_w = 32'h13; exp_e = 1'b1;
`else
    exp_h = 32'h55; exp_w = 32'hDEADBEEF; exp_e = 1'b0;
`endif
    run_op(1'b0, 2'd1, 1'b0, 32'h20, 32'h1, 32'h0, 7'd6, 6'd40);
    n_cmp++; if (!got_ok || got_val !== exp_h || got_exc !== exp_e) begin
      n_bad++; $display("FAIL mis_half: val=%h exc=%b want %h %b", got_val, got_exc, exp_h, exp_e); end
    run_op(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 32'h0, 7'd6, 6'd41);
    n_cmp++; if (!got_ok || got_val !== exp_w || got_exc !== exp_e) begin
      n_bad++; $display("FAIL mis_word: val=%h exc=%b want %h %b", got_val, got_exc, exp_w, exp_e); end
    run_op(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 32'h0, 7'd6, 6'd42);
    n_cmp++; if (!got_ok || got_val !== 32'h0 || got_exc !== 1'b0) begin
      n_bad++; $display("FAIL byte_odd: val=%h exc=%b want 00000000 0", got_val, got_exc); end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_ext();
    test_store_hazard();
    test_sq_full();
    test_flush();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
